uart_frame_deframer: RTL and testbench
======================================

// Module: uart_frame_deframer
// PURPOSE
//  Receive-side parser for the "&&payload&&" UART string protocol.
//  - Sits after uart_rx and consumes its rx_data/rx_vld byte stream.
//  - Strips the start and end delimiters and collects the payload into a byte buffer.
//  - Publishes each completed frame with its length, or raises a coded error pulse.
// PARAMETERS
//  MAX_LEN      32       payload capacity in bytes (1..255)
//  TIMEOUT_CYC  2_000_000  idle cycles allowed between bytes inside a frame before abort
// PORTS
//  sys_clk     in   1            system clock
//  sys_rst_n   in   1            asynchronous active-low reset
//  rx_data     in   8            byte from uart_rx
//  rx_vld      in   1            1-cycle strobe: rx_data is valid
//  frame_data  out  MAX_LEN*8    last good payload; byte k is at [8k+7:8k]; unused bytes are 0
//  frame_len   out  8            payload length of the last good frame
//  frame_vld   out  1            1-cycle pulse: frame_data/frame_len updated
//  frame_err   out  1            1-cycle pulse: frame aborted
//  err_code    out  2            1=overflow 2=timeout 3=checksum; held until the next frame_err
//  rx_busy     out  1            high whenever state != IDLE
// BEHAVIOUR
//  - Reset (asynchronous): all outputs 0, state IDLE, working buffer and byte count cleared.
//  - Reset mid-frame discards the partial frame; no frame_vld or frame_err is issued.
//  - States: IDLE -> HDR1 -> BODY <-> AMP -> (DONE | ERR) -> IDLE.
//    - IDLE: rx_vld & '&' -> HDR1.
//    - HDR1: rx_vld & '&' -> BODY (clear count); any other byte -> IDLE.
//    - BODY: '&' -> AMP; other byte -> store at index cnt, cnt+1.
//    - AMP: '&' -> DONE (frame end); other byte b -> store '&' and b at cnt and cnt+1,
//      cnt+2, -> BODY. A lone '&' is therefore payload data.
//    - DONE: copy working buffer to frame_data, zero-fill above cnt, set frame_len=cnt,
//      pulse frame_vld, -> IDLE.
//  - Latency: frame_vld asserts on the cycle after the rx_vld carrying the final '&'.
//  - frame_data/frame_len stay stable between frame_vld pulses; they are double-buffered.
//  - Empty frame "&&&&" is valid: frame_vld with frame_len=0.
//  - Overflow: a store that would make cnt exceed MAX_LEN gives err_code=1 and goes to ERR.
//    For a two-byte store in AMP, the check is cnt+2 > MAX_LEN.
//  - Timeout: a counter runs in HDR1/BODY/AMP and is reset by every rx_vld. When it reaches
//    TIMEOUT_CYC: err_code=2, -> ERR.
//  - If rx_vld and timeout expiry occur in the same cycle, the byte wins and no timeout fires.
//  - ERR: pulse frame_err for 1 cycle, -> IDLE. frame_data and frame_len are left unchanged.
//  - A byte arriving in the DONE or ERR cycle is dropped. uart_rx byte spacing is at least
//    ~10 bit times, so this cannot happen in normal operation.
//  - cnt is 8 bits and never wraps, because the overflow check fires first.
// CONFIGURATION
//  UART_FRAME_CKSUM_EN defined:
//    - The last payload byte is an XOR checksum of all preceding payload bytes.
//    - At DONE, mismatch or cnt==0 gives err_code=3 and frame_err; frame_data is not updated.
//    - On match, frame_len = cnt-1 and the checksum byte is zeroed in frame_data.
//  UART_FRAME_CKSUM_EN undefined: no checksum logic; err_code 3 is never produced.
// TESTING
//  1. "&&AB&&" -> frame_vld 1 cycle after the last '&'; frame_len=2; frame_data[15:0]=16'h4241;
//     all other bytes 0.
//  2. "&&A&B&&" -> frame_len=3; bytes = 'A','&','B'. Then "&&&&" -> frame_len=0, frame_vld.
//  3. MAX_LEN=4, "&&ABCDE&&" -> frame_err at 'E', err_code=1; previous frame_data unchanged;
//     next "&&Z&&" is received OK.
//  4. TIMEOUT_CYC=100, "&&AB" then silence -> frame_err exactly 100 cycles after the 'B'
//     strobe, err_code=2. A byte on cycle 100 suppresses the timeout.
//  5. Assert sys_rst_n low mid-"&&ABC" -> outputs 0 immediately; "&&Q&&" after release
//     -> frame_len=1.
//  6. CKSUM_EN: "&&" 'A' 'B' 8'h03 "&&" -> frame_len=2, frame_vld.
//     Same frame with checksum 8'h04 -> frame_err, err_code=3.

Source files
------------

// File: rtl/uart_frame_deframer_if.sv
// uart_frame_deframer_if: byte stream from uart_rx into the deframer, and the
// published frame / status signals coming back out of it.
interface uart_frame_deframer_if #(
    parameter int MAX_LEN = 32
);
    logic [7:0]           rx_data;
    logic                 rx_vld;
    logic [MAX_LEN*8-1:0] frame_data;
    logic [7:0]           frame_len;
    logic                 frame_vld;
    logic                 frame_err;
    logic [1:0]           err_code;
    logic                 rx_busy;

    // Byte source (uart_rx side) and consumer of the parsed frames.
    modport master (
        output rx_data, rx_vld,
        input  frame_data, frame_len, frame_vld, frame_err, err_code, rx_busy
    );

    // Deframer side.
    modport slave (
        input  rx_data, rx_vld,
        output frame_data, frame_len, frame_vld, frame_err, err_code, rx_busy
    );
endinterface

// File: rtl/uart_frame_deframer.sv
// uart_frame_deframer: parses the "&&payload&&" UART string protocol.
// Strips the delimiters, collects the payload in a working buffer and publishes
// it (double-buffered) with its length, or pulses frame_err with a reason code.
// Optional feature macro: UART_FRAME_CKSUM_EN -- the last payload byte is an XOR
// checksum of the preceding bytes; it is verified and stripped at frame end.
module uart_frame_deframer #(
    parameter int MAX_LEN     = 32,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    uart_frame_deframer_if.slave bus
);

    localparam logic [7:0]    DELIM    = 8'h26;
    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]    ERR_OVF  = 2'd1;
    localparam logic [1:0]    ERR_TMO  = 2'd2;
`ifdef UART_FRAME_CKSUM_EN
    localparam logic [1:0]    ERR_CKS  = 2'd3;
`endif

    typedef enum logic [2:0] {
        IDLE,
        HDR1,
        BODY,
        AMP,
        DONE,
        ERR
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [7:0]           cnt;
    logic [7:0]           work_mem [MAX_LEN];
    logic [TW-1:0]        tmo_cnt;

    logic                 is_delim;
    logic                 in_frame;
    logic                 tmo_hit;
    logic                 clr_cnt;
    logic                 st_one;
    logic                 st_two;
    logic [1:0]           err_nxt;
    logic [7:0]           len_nxt;

    logic [MAX_LEN*8-1:0] frame_data_r;
    logic [7:0]           frame_len_r;
    logic                 frame_vld_r;
    logic                 frame_err_r;
    logic [1:0]           err_code_r;

    // True when storing 'add' more bytes would push the count past capacity.
    // Done in 9 bits so cnt never has to wrap to be compared.
    function automatic logic exceeds_cap(input logic [7:0] cur, input logic [1:0] add);
        return ({1'b0, cur} + {7'd0, add}) > 9'(MAX_LEN);
    endfunction

    assign is_delim = (bus.rx_data == DELIM);
    assign in_frame = (state == HDR1) || (state == BODY) || (state == AMP);
    // An incoming byte always takes priority over expiry in the same cycle,
    // which the FSM gets by testing rx_vld before tmo_hit.
    assign tmo_hit  = in_frame && (tmo_cnt == TMO_LAST);

`ifdef UART_FRAME_CKSUM_EN
    logic [7:0] cks_acc;
    logic       cks_ok;

    // XOR over every stored byte including the checksum is zero exactly when
    // the checksum matches; an empty frame has no checksum and is rejected.
    assign cks_ok  = (cks_acc == 8'd0) && (cnt != 8'd0);
    assign len_nxt = cnt - 8'd1;
`else
    assign len_nxt = cnt;
`endif

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the store / clear / error strobes it implies.
    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        st_one    = 1'b0;
        st_two    = 1'b0;
        err_nxt   = 2'd0;
        case (state)
            IDLE: begin
                if (bus.rx_vld && is_delim) begin
                    state_nxt = HDR1;
                end
            end
            HDR1: begin
                if (bus.rx_vld) begin
                    if (is_delim) begin
                        state_nxt = BODY;
                        clr_cnt   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ERR;
                    err_nxt   = ERR_TMO;
                end
            end
            BODY: begin
                if (bus.rx_vld) begin
                    if (is_delim) begin
                        state_nxt = AMP;
                    end else if (exceeds_cap(cnt, 2'd1)) begin
                        state_nxt = ERR;
                        err_nxt   = ERR_OVF;
                    end else begin
                        st_one = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ERR;
                    err_nxt   = ERR_TMO;
                end
            end
            AMP: begin
                if (bus.rx_vld) begin
                    if (is_delim) begin
`ifdef UART_FRAME_CKSUM_EN
                        if (cks_ok) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = ERR;
                            err_nxt   = ERR_CKS;
                        end
`else
                        state_nxt = DONE;
`endif
                    end else if (exceeds_cap(cnt, 2'd2)) begin
                        // A lone '&' was data: it and the following byte go in together.
                        state_nxt = ERR;
                        err_nxt   = ERR_OVF;
                    end else begin
                        st_two    = 1'b1;
                        state_nxt = BODY;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ERR;
                    err_nxt   = ERR_TMO;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working buffer and byte count; a two-byte store writes '&' then the data byte.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= 8'd0;
            for (int k = 0; k < MAX_LEN; k++) begin
                work_mem[k] <= 8'd0;
            end
        end else begin
            if (clr_cnt) begin
                cnt <= 8'd0;
            end else if (st_one) begin
                cnt <= cnt + 8'd1;
            end else if (st_two) begin
                cnt <= cnt + 8'd2;
            end
            for (int k = 0; k < MAX_LEN; k++) begin
                if (st_one && (k == int'(cnt))) begin
                    work_mem[k] <= bus.rx_data;
                end
                if (st_two && (k == int'(cnt))) begin
                    work_mem[k] <= DELIM;
                end
                if (st_two && (k == int'(cnt) + 1)) begin
                    work_mem[k] <= bus.rx_data;
                end
            end
        end
    end

`ifdef UART_FRAME_CKSUM_EN
    // Running XOR of the payload bytes as they are stored.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cks_acc <= 8'd0;
        end else if (clr_cnt) begin
            cks_acc <= 8'd0;
        end else if (st_one) begin
            cks_acc <= cks_acc ^ bus.rx_data;
        end else if (st_two) begin
            cks_acc <= cks_acc ^ DELIM ^ bus.rx_data;
        end
    end
`endif

    // Inter-byte idle counter: counts cycles without rx_vld while inside a frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt <= '0;
        end else if (!in_frame || bus.rx_vld) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Publish on the edge into DONE/ERR so each pulse coincides with the data it announces.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_data_r <= '0;
            frame_len_r  <= 8'd0;
            frame_vld_r  <= 1'b0;
            frame_err_r  <= 1'b0;
            err_code_r   <= 2'd0;
        end else begin
            frame_vld_r <= (state_nxt == DONE);
            frame_err_r <= (state_nxt == ERR);
            if (state_nxt == ERR) begin
                err_code_r <= err_nxt;
            end
            if (state_nxt == DONE) begin
                frame_len_r <= len_nxt;
                // Zero-fill above the length; this also clears a stripped checksum byte.
                for (int k = 0; k < MAX_LEN; k++) begin
                    frame_data_r[8*k +: 8] <= (k < int'(len_nxt)) ? work_mem[k] : 8'd0;
                end
            end
        end
    end

    assign bus.frame_data = frame_data_r;
    assign bus.frame_len  = frame_len_r;
    assign bus.frame_vld  = frame_vld_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.err_code   = err_code_r;
    assign bus.rx_busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_frame_deframer.sv
// tb_uart_frame_deframer: directed bench for uart_frame_deframer with
// MAX_LEN=4 and TIMEOUT_CYC=100. Frames sent through send_frame carry an
// appended checksum byte when UART_FRAME_CKSUM_EN is defined.
module tb_uart_frame_deframer;

    localparam int         ML  = 4;
    localparam int         TO  = 100;
    localparam logic [7:0] AMP = 8'h26;
`ifdef UART_FRAME_CKSUM_EN
    localparam int         CK  = 1;
`else
    localparam int         CK  = 0;
`endif

    logic            sys_clk;
    logic            sys_rst_n;
    int              n_chk;
    int              n_fail;
    logic [7:0]      q[$];
    logic [ML*8-1:0] prev_data;
    logic [7:0]      prev_len;

    uart_frame_deframer_if #(.MAX_LEN(ML)) bus ();

    uart_frame_deframer #(
        .MAX_LEN     (ML),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // One-cycle strobe; returns 1 time unit after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_vld  = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.rx_vld  = 1'b0;
    endtask

    task automatic send_frame(input string tag, input logic [7:0] pl[$]);
        logic [7:0]      ck;
        logic [ML*8-1:0] ed;
        ck = 8'd0;
        ed = '0;
        send_byte(AMP); idle(2);
        send_byte(AMP); idle(2);
        foreach (pl[i]) begin
            send_byte(pl[i]);
            ck = ck ^ pl[i];
            ed[8*i +: 8] = pl[i];
            idle(2);
        end
`ifdef UART_FRAME_CKSUM_EN
        send_byte(ck); idle(2);
`endif
        send_byte(AMP); idle(2);
        send_byte(AMP);
        check({tag, "_vld"},  64'(bus.frame_vld),  64'd1);
        check({tag, "_err"},  64'(bus.frame_err),  64'd0);
        check({tag, "_len"},  64'(bus.frame_len),  64'(pl.size()));
        check({tag, "_data"}, 64'(bus.frame_data), 64'(ed));
        idle(1);
        check({tag, "_vld_pulse"}, 64'(bus.frame_vld), 64'd0);
        check({tag, "_idle"},      64'(bus.rx_busy),   64'd0);
        prev_data = ed;
        prev_len  = 8'(pl.size());
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        sys_rst_n   = 1'b0;
        bus.rx_data = 8'd0;
        bus.rx_vld  = 1'b0;
        prev_data   = '0;
        prev_len    = 8'd0;
        idle(3);

        // Reset state
        check("rst_data", 64'(bus.frame_data), 64'd0);
        check("rst_len",  64'(bus.frame_len),  64'd0);
        check("rst_vld",  64'(bus.frame_vld),  64'd0);
        check("rst_err",  64'(bus.frame_err),  64'd0);
        check("rst_code", 64'(bus.err_code),   64'd0);
        check("rst_busy", 64'(bus.rx_busy),    64'd0);
        sys_rst_n = 1'b1;
        idle(2);

        // Basic frame "&&AB&&"
        q = '{8'h41, 8'h42};
        send_frame("t1", q);
        check("t1_lit", 64'(bus.frame_data), 64'h0000_4241);

        // Lone '&' is payload: "&&A&B&&"
        q = '{8'h41, 8'h26, 8'h42};
        send_frame("t2", q);
        check("t2_lit", 64'(bus.frame_data), 64'h0042_2641);

        // Empty frame "&&&&"
        send_byte(AMP); idle(2); send_byte(AMP); idle(2);
        send_byte(AMP); idle(2); send_byte(AMP);
`ifdef UART_FRAME_CKSUM_EN
        check("empty_err",  64'(bus.frame_err),  64'd1);
        check("empty_code", 64'(bus.err_code),   64'd3);
        check("empty_keep", 64'(bus.frame_data), 64'(prev_data));
`else
        check("empty_vld",  64'(bus.frame_vld),  64'd1);
        check("empty_len",  64'(bus.frame_len),  64'd0);
        check("empty_data", 64'(bus.frame_data), 64'd0);
`endif
        idle(3);

        // Exactly full buffer is accepted
        q = {};
        for (int i = 0; i < ML - CK; i++) q.push_back(8'(8'h41 + i));
        send_frame("full", q);
        idle(2);

        // Overflow on a single store: "&&ABCDE"
        send_byte(AMP); idle(2); send_byte(AMP); idle(2);
        send_byte(8'h41); idle(2); send_byte(8'h42); idle(2);
        send_byte(8'h43); idle(2); send_byte(8'h44); idle(2);
        check("ovf_busy", 64'(bus.rx_busy), 64'd1);
        send_byte(8'h45);
        check("ovf_err",  64'(bus.frame_err),  64'd1);
        check("ovf_code", 64'(bus.err_code),   64'd1);
        check("ovf_vld",  64'(bus.frame_vld),  64'd0);
        check("ovf_keep", 64'(bus.frame_data), 64'(prev_data));
        check("ovf_klen", 64'(bus.frame_len),  64'(prev_len));
        idle(1);
        check("ovf_pulse", 64'(bus.frame_err), 64'd0);
        check("ovf_hold",  64'(bus.err_code),  64'd1);
        idle(2);

        // Recovery after overflow: "&&Z&&"
        q = '{8'h5A};
        send_frame("z", q);
        check("z_lit", 64'(bus.frame_data), 64'h0000_005A);
        idle(2);

        // Timeout: "&&AB" then silence
        send_byte(AMP); idle(2); send_byte(AMP); idle(2);
        send_byte(8'h41); idle(2); send_byte(8'h42);
        repeat (TO - 1) @(posedge sys_clk);
        #1;
        check("tmo_early", 64'(bus.frame_err), 64'd0);
        check("tmo_busy",  64'(bus.rx_busy),   64'd1);
        idle(1);
        check("tmo_err",  64'(bus.frame_err),  64'd1);
        check("tmo_code", 64'(bus.err_code),   64'd2);
        check("tmo_keep", 64'(bus.frame_data), 64'(prev_data));
        idle(3);

        // Byte landing on the expiry cycle suppresses the timeout
        send_byte(AMP); idle(2); send_byte(AMP); idle(2);
        send_byte(8'h41); idle(2); send_byte(8'h42);
        repeat (TO - 1) @(posedge sys_clk);
        #1;
        send_byte(8'h43);
        check("sup_err",  64'(bus.frame_err), 64'd0);
        check("sup_busy", 64'(bus.rx_busy),   64'd1);
        idle(5);
        check("sup_err2", 64'(bus.frame_err), 64'd0);
`ifdef UART_FRAME_CKSUM_EN
        send_byte(8'h40); idle(2);
`endif
        send_byte(AMP); idle(2); send_byte(AMP);
        check("sup_vld",  64'(bus.frame_vld),  64'd1);
        check("sup_len",  64'(bus.frame_len),  64'd3);
        check("sup_data", 64'(bus.frame_data), 64'h0043_4241);
        prev_data = 32'h0043_4241;
        prev_len  = 8'd3;
        idle(3);

        // Overflow on the two-byte store: "&&ABC&D" with three bytes already held
        send_byte(AMP); idle(2); send_byte(AMP); idle(2);
        send_byte(8'h41); idle(2); send_byte(8'h42); idle(2);
        send_byte(8'h43); idle(2); send_byte(AMP); idle(2);
        send_byte(8'h44);
        check("ovf2_err",  64'(bus.frame_err), 64'd1);
        check("ovf2_code", 64'(bus.err_code),  64'd1);
        check("ovf2_klen", 64'(bus.frame_len), 64'(prev_len));
        idle(3);

        // Checksum frames: "&&" 'A' 'B' 03 "&&" then the same with 04
        q = '{8'h41, 8'h42};
        send_frame("ck_good", q);
        idle(2);
        send_byte(AMP); idle(2); send_byte(AMP); idle(2);
        send_byte(8'h41); idle(2); send_byte(8'h42); idle(2);
        send_byte(8'h04); idle(2);
        send_byte(AMP); idle(2); send_byte(AMP);
`ifdef UART_FRAME_CKSUM_EN
        check("ck_bad_err",  64'(bus.frame_err),  64'd1);
        check("ck_bad_code", 64'(bus.err_code),   64'd3);
        check("ck_bad_keep", 64'(bus.frame_data), 64'h0000_4241);
`else
        check("ck_bad_vld",  64'(bus.frame_vld),  64'd1);
        check("ck_bad_len",  64'(bus.frame_len),  64'd3);
        check("ck_bad_data", 64'(bus.frame_data), 64'h0004_4241);
`endif
        idle(3);

        // Reset in the middle of "&&ABC"
        send_byte(AMP); idle(2); send_byte(AMP); idle(2);
        send_byte(8'h41); idle(2); send_byte(8'h42); idle(2);
        send_byte(8'h43);
        sys_rst_n = 1'b0;
        #2;
        check("mrst_data", 64'(bus.frame_data), 64'd0);
        check("mrst_len",  64'(bus.frame_len),  64'd0);
        check("mrst_code", 64'(bus.err_code),   64'd0);
        check("mrst_busy", 64'(bus.rx_busy),    64'd0);
        idle(2);
        check("mrst_vld",  64'(bus.frame_vld),  64'd0);
        check("mrst_err",  64'(bus.frame_err),  64'd0);
        sys_rst_n = 1'b1;
        idle(2);
        q = '{8'h51};
        send_frame("q", q);
        check("q_lit", 64'(bus.frame_data), 64'h0000_0051);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
